// File: rtl/log_histogram.sv
// Eight-bin magnitude histogram fed by the floor-log2 encoder.
// Saturating per-bin counters with a sequential dump that can clear bins as it reads them.
module log_histogram #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [2:0]         in_bin,
    input  logic               clear,
    input  logic               dump_start,
    input  logic               dump_clr,
    output logic               busy,
    output logic               out_valid,
    output logic [2:0]         out_bin,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_sat,
    output logic               dump_done,
    output logic [CNT_W+2:0]   total
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W+2:0] TOT_MAX = '1;

    typedef enum logic {IDLE, DUMP} state_t;

    state_t             state_q;
    logic [2:0]         k_q;
    logic               clr_mode_q;
    logic [CNT_W-1:0]   cnt_q [8];
    logic [CNT_W-1:0]   cnt_d [8];
    logic [7:0]         sat_q;
    logic [7:0]         sat_d;
    logic [CNT_W+2:0]   total_q;
    logic [CNT_W+2:0]   total_d;
    logic               busy_q;
    logic               out_valid_q;
    logic [2:0]         out_bin_q;
    logic [CNT_W-1:0]   out_count_q;
    logic               out_sat_q;
    logic               dump_done_q;

    logic               beat_en;
    logic [2:0]         beat_k;
    logic               beat_clr;

    // Bin 0 is emitted on the accepting edge so beats appear right after dump_start.
    always_comb begin
        beat_en  = 1'b0;
        beat_k   = k_q;
        beat_clr = clr_mode_q;
        if (state_q == IDLE) begin
            beat_en  = dump_start;
            beat_k   = 3'd0;
            beat_clr = dump_clr;
        end else begin
            beat_en  = 1'b1;
        end
    end

    // Counter next-state: read-clear of the dumped bin first, then the new sample.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
            sat_d[i] = sat_q[i];
            if (beat_en && beat_clr && beat_k == 3'(i)) begin
                cnt_d[i] = '0;
                sat_d[i] = 1'b0;
            end
            if (in_valid && in_bin == 3'(i)) begin
                if (cnt_d[i] == CNT_MAX) sat_d[i] = 1'b1;
                else                     cnt_d[i] = cnt_d[i] + 1'b1;
            end
        end
        total_d = total_q;
        if (in_valid && total_q != TOT_MAX) total_d = total_q + 1'b1;
    end

    // Counters, dump FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
            sat_q       <= '0;
            total_q     <= '0;
            state_q     <= IDLE;
            k_q         <= '0;
            clr_mode_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
            dump_done_q <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
            sat_q       <= '0;
            total_q     <= '0;
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            dump_done_q <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
            sat_q   <= sat_d;
            total_q <= total_d;
            if (beat_en) begin
                busy_q      <= 1'b1;
                out_valid_q <= 1'b1;
                out_bin_q   <= beat_k;
                out_count_q <= cnt_q[beat_k];
                out_sat_q   <= sat_q[beat_k];
                dump_done_q <= (beat_k == 3'd7);
                if (state_q == IDLE) clr_mode_q <= dump_clr;
                if (beat_k == 3'd7) begin
                    state_q <= IDLE;
                end else begin
                    state_q <= DUMP;
                    k_q     <= beat_k + 3'd1;
                end
            end else begin
                busy_q      <= 1'b0;
                out_valid_q <= 1'b0;
                dump_done_q <= 1'b0;
            end
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_bin   = out_bin_q;
    assign out_count = out_count_q;
    assign out_sat   = out_sat_q;
    assign dump_done = dump_done_q;
    assign total     = total_q;

endmodule

// File: tb/tb_log_histogram.sv
// Bench for log_histogram (CNT_W=4): directed scenarios with literal
// expectations plus a random phase checked every cycle against a model.
module tb_log_histogram;

    localparam int CW   = 4;
    localparam int CMAX = 15;
    localparam int TMAX = 127;

    logic          clk = 1'b0;
    logic          reset, in_valid, clear, dump_start, dump_clr;
    logic [2:0]    in_bin;
    logic          busy, out_valid, out_sat, dump_done;
    logic [2:0]    out_bin;
    logic [CW-1:0] out_count;
    logic [CW+2:0] total;

    int checks = 0;
    int failures = 0;

    log_histogram #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bin(in_bin),
        .clear(clear), .dump_start(dump_start), .dump_clr(dump_clr),
        .busy(busy), .out_valid(out_valid), .out_bin(out_bin),
        .out_count(out_count), .out_sat(out_sat), .dump_done(dump_done),
        .total(total)
    );

    always #5 clk = ~clk;

    // Behavioural model: histogram arrays and a dump position (-1 when idle).
    int m_cnt [8];
    int m_sat [8];
    int m_total = 0;
    int m_pos = -1;
    int m_clr = 0;
    int m_busy = 0, m_ov = 0, m_bin = 0, m_count = 0, m_osat = 0, m_done = 0;

    always @(posedge clk) begin
        int b;
        if (reset) begin
            for (int i = 0; i < 8; i++) begin m_cnt[i] = 0; m_sat[i] = 0; end
            m_total = 0; m_pos = -1; m_clr = 0;
            m_busy = 0; m_ov = 0; m_bin = 0; m_count = 0; m_osat = 0; m_done = 0;
        end else if (clear) begin
            for (int i = 0; i < 8; i++) begin m_cnt[i] = 0; m_sat[i] = 0; end
            m_total = 0; m_pos = -1;
            m_busy = 0; m_ov = 0; m_done = 0;
        end else begin
            b = -1;
            if (m_pos < 0 && dump_start) begin b = 0; m_clr = dump_clr; end
            else if (m_pos >= 0) b = m_pos;
            if (b >= 0) begin
                m_ov = 1; m_busy = 1; m_bin = b;
                m_count = m_cnt[b]; m_osat = m_sat[b];
                m_done = (b == 7);
                m_pos = (b == 7) ? -1 : b + 1;
                if (m_clr != 0) begin m_cnt[b] = 0; m_sat[b] = 0; end
            end else begin
                m_ov = 0; m_busy = 0; m_done = 0;
            end
            if (in_valid) begin
                if (m_cnt[in_bin] == CMAX) m_sat[in_bin] = 1;
                else m_cnt[in_bin] = m_cnt[in_bin] + 1;
                if (m_total < TMAX) m_total = m_total + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Beat capture for the directed literal checks.
    int cap_cnt [8];
    int cap_sat [8];
    int beat_n = 0, done_n = 0;

    task automatic start_caps();
        for (int i = 0; i < 8; i++) begin cap_cnt[i] = 99; cap_sat[i] = 99; end
        beat_n = 0; done_n = 0;
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("dump_done", 32'(dump_done), 32'(m_done));
        chk("total", 32'(total), 32'(m_total));
        chk("out_bin", 32'(out_bin), 32'(m_bin));
        chk("out_count", 32'(out_count), 32'(m_count));
        chk("out_sat", 32'(out_sat), 32'(m_osat));
        if (out_valid === 1'b1) begin
            cap_cnt[out_bin] = int'(out_count);
            cap_sat[out_bin] = int'(out_sat);
            beat_n++;
        end
        if (dump_done === 1'b1) done_n++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int b);
        in_valid = 1'b1; in_bin = 3'(b);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic dump(input logic c);
        dump_start = 1'b1; dump_clr = c;
        tick();
        dump_start = 1'b0; dump_clr = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_bin = '0;
        clear = 1'b0; dump_start = 1'b0; dump_clr = 1'b0;
        start_caps();
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("rst_total", 32'(total), 0);
        chk("rst_busy", 32'(busy), 0);

        // One sample per bin plus three extra 5s.
        for (int b = 0; b < 8; b++) send(b);
        repeat (3) send(5);
        start_caps();
        dump(1'b0);
        repeat (10) tick();
        for (int k = 0; k < 8; k++) chk("t1_bin", 32'(cap_cnt[k]), (k == 5) ? 4 : 1);
        chk("t1_beats", 32'(beat_n), 8);
        chk("t1_done", 32'(done_n), 1);
        chk("t1_total", 32'(total), 11);
        chk("t1_model_total", 32'(m_total), 11);

        // Saturation of bin 2.
        pulse_clear();
        repeat (17) send(2);
        start_caps();
        dump(1'b0);
        repeat (10) tick();
        for (int k = 0; k < 8; k++) begin
            chk("t2_cnt", 32'(cap_cnt[k]), (k == 2) ? CMAX : 0);
            chk("t2_sat", 32'(cap_sat[k]), (k == 2) ? 1 : 0);
        end
        chk("t2_total", 32'(total), 17);

        // Clearing dump with bin 3 sampled throughout.
        pulse_clear();
        repeat (2) send(3);
        start_caps();
        in_valid = 1'b1; in_bin = 3'd3;
        dump_start = 1'b1; dump_clr = 1'b1;
        tick();
        dump_start = 1'b0; dump_clr = 1'b0;
        repeat (7) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("t3_first", 32'(cap_cnt[3]), 5);
        start_caps();
        dump(1'b0);
        repeat (10) tick();
        chk("t3_second", 32'(cap_cnt[3]), 5);
        chk("t3_total", 32'(total), 10);

        // Clear on the 4th beat aborts the dump and drops the sample.
        pulse_clear();
        send(1); send(1); send(6);
        start_caps();
        dump(1'b0);
        repeat (3) tick();
        clear = 1'b1; in_valid = 1'b1; in_bin = 3'd4;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk("t4_ov", 32'(out_valid), 0);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_total", 32'(total), 0);
        chk("t4_beats", 32'(beat_n), 4);
        chk("t4_done", 32'(done_n), 0);
        start_caps();
        dump(1'b0);
        repeat (10) tick();
        for (int k = 0; k < 8; k++) chk("t4_zero", 32'(cap_cnt[k]), 0);

        // dump_start mid-dump is ignored; on the done cycle it chains.
        start_caps();
        dump(1'b0);
        repeat (2) tick();
        dump(1'b0);
        repeat (10) tick();
        chk("t5_beats", 32'(beat_n), 8);
        chk("t5_done", 32'(done_n), 1);
        start_caps();
        dump(1'b0);
        repeat (7) tick();
        chk("t5_done_now", 32'(dump_done), 1);
        dump(1'b0);
        chk("t5_chain_ov", 32'(out_valid), 1);
        chk("t5_chain_bin", 32'(out_bin), 0);
        repeat (12) tick();
        chk("t5_chain_beats", 32'(beat_n), 16);
        chk("t5_chain_done", 32'(done_n), 2);

        // Reset in the middle of a dump.
        send(7); send(0); send(0);
        dump(1'b0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_ov", 32'(out_valid), 0);
        chk("t6_count", 32'(out_count), 0);
        chk("t6_bin", 32'(out_bin), 0);
        chk("t6_total", 32'(total), 0);
        start_caps();
        dump(1'b0);
        repeat (10) tick();
        for (int k = 0; k < 8; k++) chk("t6_zero", 32'(cap_cnt[k]), 0);

        // Random phase, checked every cycle by the compare process.
        for (int n = 0; n < 4000; n++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_bin     = 3'($urandom_range(0, 7));
            dump_start = ($urandom_range(0, 7) == 0);
            dump_clr   = ($urandom_range(0, 1) == 1);
            clear      = ($urandom_range(0, 149) == 0);
            reset      = ($urandom_range(0, 599) == 0);
            tick();
        end
        in_valid = 1'b0; dump_start = 1'b0; clear = 1'b0; reset = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
